// File: rtl/sd_sync_cleaner.sv
// sd_sync_cleaner: sits behind the scandoubler. Retimes vsync onto the hsync
// leading edge, regenerates hblank/vblank/de from porch/active counts and
// forces colour to zero outside the active window. Every output is one
// ce_pix cycle behind its inputs; colour and syncs leave on the same cycle.
//
// Vertical FSM
//   state    | meaning
//   V_SYNC   | vsync in progress, or waiting for a first full vsync after reset
//   V_BACK   | counting back-porch lines after vsync ended
//   V_ACTIVE | counting active lines
//   V_FRONT  | front porch, idle until vs_out falls again
module sd_sync_cleaner #(
    parameter int HCNT_WIDTH = 10,
    parameter int VCNT_WIDTH = 10,
    parameter int H_BP       = 48,
    parameter int H_ACT      = 640,
    parameter int V_BP       = 33,
    parameter int V_ACT      = 480
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ce_pix,
    input  logic       hs_in,
    input  logic       vs_in,
    input  logic [5:0] r_in,
    input  logic [5:0] g_in,
    input  logic [5:0] b_in,
    output logic       hs_out,
    output logic       vs_out,
    output logic [5:0] r_out,
    output logic [5:0] g_out,
    output logic [5:0] b_out,
    output logic       de,
    output logic       hblank,
    output logic       vblank
);

    typedef enum logic [1:0] {
        V_SYNC   = 2'd0,
        V_BACK   = 2'd1,
        V_ACTIVE = 2'd2,
        V_FRONT  = 2'd3
    } vstate_t;

    localparam logic [HCNT_WIDTH-1:0] HCNT_MAX = '1;
    localparam logic [VCNT_WIDTH-1:0] VCNT_MAX = '1;

    vstate_t r_state;
    vstate_t w_state_nxt;

    logic [HCNT_WIDTH-1:0] r_hcnt;
    logic [HCNT_WIDTH-1:0] w_hcnt_nxt;
    logic [VCNT_WIDTH-1:0] r_vcnt;
    logic [VCNT_WIDTH-1:0] w_vcnt_nxt;
    logic [VCNT_WIDTH-1:0] w_vcnt_inc;

    logic       r_hs_prev;
    logic       r_hs_out;
    logic       r_vs_out;
    logic [5:0] r_r_out;
    logic [5:0] r_g_out;
    logic [5:0] r_b_out;
    logic       r_de;
    logic       r_hblank;
    logic       r_vblank;

    logic w_hs_fall;
    logic w_hs_rise;
    logic w_vs_fall;
    logic w_vs_rise;
    logic w_hact;
    logic w_vact_nxt;
    logic w_de_nxt;

    // Edge detection and counter next values; vsync is only ever sampled on hs_fall,
    // so a vs_in change in the same cycle as hs_fall is taken by that hs_fall.
    assign w_hs_fall  = ~hs_in & r_hs_prev;
    assign w_hs_rise  = hs_in & ~r_hs_prev;
    assign w_vs_fall  = w_hs_fall & r_vs_out & ~vs_in;
    assign w_vs_rise  = w_hs_fall & ~r_vs_out & vs_in;
    assign w_hcnt_nxt = w_hs_rise ? '0 : ((r_hcnt == HCNT_MAX) ? r_hcnt : r_hcnt + 1'b1);
    assign w_vcnt_inc = (r_vcnt == VCNT_MAX) ? r_vcnt : r_vcnt + 1'b1;

    // Horizontal tracking and retimed vsync; only advance on ce_pix.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_hs_prev <= 1'b1;
            r_hcnt    <= '0;
            r_vs_out  <= 1'b1;
        end else if (ce_pix) begin
            r_hs_prev <= hs_in;
            r_hcnt    <= w_hcnt_nxt;
            if (w_hs_fall) begin
                r_vs_out <= vs_in;
            end
        end
    end

    // Vertical state register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= V_SYNC;
            r_vcnt  <= '0;
        end else if (ce_pix) begin
            r_state <= w_state_nxt;
            r_vcnt  <= w_vcnt_nxt;
        end
    end

    // Vertical next state. Leaving V_SYNC needs a real vs_out rise, so a reset
    // mid-frame waits for a complete vsync before counting porch lines.
    always_comb begin
        w_state_nxt = r_state;
        w_vcnt_nxt  = r_vcnt;
        if (w_hs_fall) begin
            if (w_vs_fall) begin
                w_state_nxt = V_SYNC;
            end else begin
                case (r_state)
                    V_SYNC: begin
                        if (w_vs_rise) begin
                            w_vcnt_nxt = '0;
                            if (V_BP == 0) begin
                                w_state_nxt = V_ACTIVE;
                            end else begin
                                w_state_nxt = V_BACK;
                            end
                        end
                    end
                    V_BACK: begin
                        if (r_vcnt == VCNT_WIDTH'(V_BP - 1)) begin
                            w_state_nxt = V_ACTIVE;
                            w_vcnt_nxt  = '0;
                        end else begin
                            w_vcnt_nxt = w_vcnt_inc;
                        end
                    end
                    V_ACTIVE: begin
                        w_vcnt_nxt = w_vcnt_inc;
                        if (r_vcnt == VCNT_WIDTH'(V_ACT - 1)) begin
                            w_state_nxt = V_FRONT;
                        end
                    end
                    default: begin
                        w_state_nxt = r_state;
                    end
                endcase
            end
        end
    end

    // Output decode from the values the registers are about to take.
    always_comb begin
        w_hact     = hs_in && (32'(w_hcnt_nxt) >= H_BP) && (32'(w_hcnt_nxt) < H_BP + H_ACT);
        w_vact_nxt = (w_state_nxt == V_ACTIVE);
        w_de_nxt   = w_hact & w_vact_nxt;
    end

    // Output register: syncs, blanking, de and colour all move together.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_hs_out <= 1'b1;
            r_r_out  <= '0;
            r_g_out  <= '0;
            r_b_out  <= '0;
            r_de     <= 1'b0;
            r_hblank <= 1'b1;
            r_vblank <= 1'b1;
        end else if (ce_pix) begin
            r_hs_out <= hs_in;
            r_r_out  <= w_de_nxt ? r_in : 6'd0;
            r_g_out  <= w_de_nxt ? g_in : 6'd0;
            r_b_out  <= w_de_nxt ? b_in : 6'd0;
            r_de     <= w_de_nxt;
            r_hblank <= ~w_hact;
            r_vblank <= ~w_vact_nxt;
        end
    end

    assign hs_out = r_hs_out;
    assign vs_out = r_vs_out;
    assign r_out  = r_r_out;
    assign g_out  = r_g_out;
    assign b_out  = r_b_out;
    assign de     = r_de;
    assign hblank = r_hblank;
    assign vblank = r_vblank;

endmodule

// File: tb/tb_sd_sync_cleaner.sv
// Bench for sd_sync_cleaner with a scaled-down raster (64 px x 20 lines) so
// complete frames stay short. Every cycle is compared against a line/pixel
// bookkeeping model; frame-level statistics are checked against constants.
module tb_sd_sync_cleaner;

    localparam int H_BP     = 8;
    localparam int H_ACT    = 40;
    localparam int V_BP     = 4;
    localparam int V_ACT    = 12;
    localparam int HS_LOW   = 12;
    localparam int LINE     = 64;
    localparam int VS_LINES = 2;
    localparam int V_FP     = 2;
    localparam int NLINES   = VS_LINES + V_BP + V_ACT + V_FP;
    localparam int HMAX     = 1023;
    localparam int SHORT_H  = 30;
    localparam int SKEW     = 37;
    localparam int EARLY    = 6;
    localparam logic [22:0] RESET_VEC = {1'b1, 1'b1, 18'd0, 1'b0, 1'b1, 1'b1};

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic       ce_pix  = 1'b0;
    logic       hs_in   = 1'b1;
    logic       vs_in   = 1'b1;
    logic [5:0] r_in    = '0;
    logic [5:0] g_in    = '0;
    logic [5:0] b_in    = '0;
    logic       hs_out, vs_out, de, hblank, vblank;
    logic [5:0] r_out, g_out, b_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_sys = ~clk_sys;

    sd_sync_cleaner #(
        .HCNT_WIDTH(10), .VCNT_WIDTH(10),
        .H_BP(H_BP), .H_ACT(H_ACT), .V_BP(V_BP), .V_ACT(V_ACT)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ce_pix(ce_pix),
        .hs_in(hs_in), .vs_in(vs_in), .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .hs_out(hs_out), .vs_out(vs_out), .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .de(de), .hblank(hblank), .vblank(vblank)
    );

    // ---------------- reference model ----------------
    bit          m_hs_prev;
    int          m_age;       // pixels since last hs rise
    bit          m_vs_last;   // vs_in seen at the last hs fall
    int          m_since;     // hs falls since vsync ended, -1 = no valid vsync end
    logic [22:0] m_exp;

    function automatic logic [22:0] dut_vec();
        return {hs_out, vs_out, r_out, g_out, b_out, de, hblank, vblank};
    endfunction

    task automatic model_reset();
        m_hs_prev = 1'b1;
        m_age     = 0;
        m_vs_last = 1'b1;
        m_since   = -1;
        m_exp     = RESET_VEC;
    endtask

    task automatic model_update();
        bit fall, rise, hact, vact, d;
        fall = !hs_in && m_hs_prev;
        rise = hs_in && !m_hs_prev;
        m_age = rise ? 0 : ((m_age < HMAX) ? m_age + 1 : HMAX);
        if (fall) begin
            if (vs_in && !m_vs_last) m_since = 0;
            else if (!vs_in)         m_since = -1;
            else if (m_since >= 0)   m_since = m_since + 1;
            m_vs_last = vs_in;
        end
        m_hs_prev = hs_in;
        vact = (m_since >= V_BP) && (m_since < V_BP + V_ACT);
        hact = hs_in && (m_age >= H_BP) && (m_age < H_BP + H_ACT);
        d = hact && vact;
        m_exp = {hs_in, m_vs_last, d ? r_in : 6'd0, d ? g_in : 6'd0, d ? b_in : 6'd0,
                 d, ~hact, ~vact};
    endtask

    task automatic check23(input string nm, input logic [22:0] act, input logic [22:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input string nm);
        @(posedge clk_sys);
        if (ce_pix && reset_n) model_update();
        #1;
        check23(nm, dut_vec(), m_exp);
    endtask

    // ---------------- frame driver and measurements ----------------
    int          ce_mode  = 0;   // 1: a disabled cycle with junk inputs before every pixel
    int          rec_mode = 0;   // 1: record outputs, 2: compare against record
    logic [22:0] rec [0:LINE*NLINES-1];
    int f_total, f_lines, f_first_line, f_first_px;
    int f_line_de [0:63];
    int f_vsf_line, f_vsf_px, f_vsr_line, f_vsr_px;
    bit f_vb_start;

    task automatic run_frame(input int nlines, input int skew, input int short_line,
                             input bit vs_en, input int stop_line, input int stop_px);
        int  len, pos, lde;
        bit  prev_vs;
        f_total = 0; f_lines = 0; f_first_line = -1; f_first_px = -1;
        f_vsf_line = -1; f_vsf_px = -1; f_vsr_line = -1; f_vsr_px = -1;
        prev_vs = vs_out;
        for (int l = 0; l < nlines; l++) begin
            lde = 0;
            len = (l == short_line) ? HS_LOW + SHORT_H : LINE;
            for (int px = 0; px < len; px++) begin
                if (l == stop_line && px == stop_px) return;
                if (ce_mode != 0) begin
                    ce_pix = 1'b0;
                    hs_in = 1'($urandom); vs_in = 1'($urandom);
                    r_in = 6'($urandom); g_in = 6'($urandom); b_in = 6'($urandom);
                    step("gated_idle");
                end
                pos = l * LINE + px;
                ce_pix = 1'b1;
                hs_in  = (px >= HS_LOW);
                vs_in  = !(vs_en && pos >= skew && pos < VS_LINES * LINE + skew);
                r_in   = 6'(px);
                g_in   = 6'(l);
                b_in   = 6'(px ^ l);
                step("stream");
                if (pos < LINE * NLINES) begin
                    if (rec_mode == 1) rec[pos] = dut_vec();
                    else if (rec_mode == 2) check23("gated_vs_full_rate", dut_vec(), rec[pos]);
                end
                if (l == 0 && px == 0) f_vb_start = vblank;
                if (de) begin
                    lde++;
                    if (f_first_line < 0) begin f_first_line = l; f_first_px = px; end
                end
                if (vs_out != prev_vs) begin
                    if (!vs_out) begin f_vsf_line = l; f_vsf_px = px; end
                    else         begin f_vsr_line = l; f_vsr_px = px; end
                end
                prev_vs = vs_out;
            end
            if (l < 64) f_line_de[l] = lde;
            f_total += lde;
            if (lde > 0) f_lines++;
        end
    endtask

    task automatic check_frame(input string nm, input int first_line);
        check_int({nm, "_de_total"}, f_total, V_ACT * H_ACT);
        check_int({nm, "_de_lines"}, f_lines, V_ACT);
        check_int({nm, "_first_line"}, f_first_line, first_line);
        check_int({nm, "_first_px"}, f_first_px, HS_LOW + H_BP);
    endtask

    task automatic run_random(input int nlines);
        bit cur_vs, nxt_vs;
        int vs_timer, len, hl, off, gl, px;
        cur_vs = 1'b1; vs_timer = 0;
        for (int k = 0; k < nlines; k++) begin
            len = $urandom_range(30, 90);
            hl  = $urandom_range(3, 12);
            off = $urandom_range(0, len - 1);
            if (vs_timer == 0) vs_timer = $urandom_range(8, 26);
            vs_timer--;
            nxt_vs = (vs_timer >= 2);
            gl = ($urandom_range(0, 7) == 0) ? $urandom_range(hl + 1, len - 1) : -100;
            px = 0;
            while (px < len) begin
                ce_pix = ($urandom_range(0, 3) != 0);
                hs_in  = (px >= hl);
                vs_in  = (px < off) ? cur_vs : nxt_vs;
                if (px >= gl && px < gl + 3) vs_in = ~vs_in;
                r_in = 6'($urandom); g_in = 6'($urandom); b_in = 6'($urandom);
                step("random");
                if (ce_pix) px++;
            end
            cur_vs = nxt_vs;
        end
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        bit         ce, hs, vs;
        logic [5:0] r;
        bit         e_hs, e_vs, e_hb, e_vb, e_de;
    } vec_t;
    vec_t tbl [0:8];

    initial begin
        tbl[0] = '{1'b1, 1'b1, 1'b0, 6'd5,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 6'd7,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 6'd9,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 6'd11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 6'd13, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 6'd15, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 6'd17, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 6'd19, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[8] = '{1'b1, 1'b1, 1'b1, 6'd21, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        model_reset();
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1 check23("reset_values", dut_vec(), RESET_VEC);
        repeat (3) step("reset_hold");
        #2 reset_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            ce_pix = tbl[i].ce; hs_in = tbl[i].hs; vs_in = tbl[i].vs;
            r_in = tbl[i].r; g_in = tbl[i].r; b_in = tbl[i].r;
            step("table_model");
            check23("table_vec", dut_vec(),
                    {tbl[i].e_hs, tbl[i].e_vs, 18'd0, tbl[i].e_de, tbl[i].e_hb, tbl[i].e_vb});
        end

        // nominal frames, second one recorded for the gated comparison
        run_frame(NLINES, 0, -1, 1'b1, -1, -1);
        check_frame("nominal1", VS_LINES + V_BP);
        check_int("nominal_vs_fall_line", f_vsf_line, 0);
        check_int("nominal_vs_rise_line", f_vsr_line, VS_LINES);
        rec_mode = 1;
        run_frame(NLINES, 0, -1, 1'b1, -1, -1);
        check_frame("nominal2", VS_LINES + V_BP);

        // ce_pix every other cycle
        ce_mode = 1; rec_mode = 2;
        run_frame(NLINES, 0, -1, 1'b1, -1, -1);
        check_frame("gated", VS_LINES + V_BP);
        ce_mode = 0; rec_mode = 0;

        // vsync skewed into the middle of a line
        run_frame(NLINES, SKEW, -1, 1'b1, -1, -1);
        check_int("skew_vs_fall_line", f_vsf_line, 1);
        check_int("skew_vs_fall_px", f_vsf_px, 0);
        check_int("skew_vs_rise_line", f_vsr_line, 1 + VS_LINES);
        check_int("skew_vs_rise_px", f_vsr_px, 0);
        check_frame("skew", 1 + VS_LINES + V_BP);

        // short line inside the active window
        run_frame(NLINES, 0, VS_LINES + V_BP + 3, 1'b1, -1, -1);
        check_int("short_line_de", f_line_de[VS_LINES + V_BP + 3], SHORT_H - H_BP);
        check_int("after_short_line_de", f_line_de[VS_LINES + V_BP + 4], H_ACT);
        check_int("short_frame_total", f_total, V_ACT * H_ACT - (H_ACT - (SHORT_H - H_BP)));

        // early vsync after EARLY active lines, then a normal frame
        run_frame(VS_LINES + V_BP + EARLY, 0, -1, 1'b1, -1, -1);
        check_int("early_de_total", f_total, EARLY * H_ACT);
        check_int("early_de_lines", f_lines, EARLY);
        run_frame(NLINES, 0, -1, 1'b1, -1, -1);
        check_int("early_vblank_on_hs_fall", int'(f_vb_start), 1);
        check_frame("after_early", VS_LINES + V_BP);

        // reset in the middle of an active line
        run_frame(NLINES, 0, -1, 1'b1, VS_LINES + V_BP + 4, 30);
        @(posedge clk_sys);
        #3 reset_n = 1'b0;
        #1 check23("reset_mid_line", dut_vec(), RESET_VEC);
        model_reset();
        ce_pix = 1'b1;
        repeat (3) step("reset_mid_hold");
        #2 reset_n = 1'b1;
        run_frame(40, 0, -1, 1'b0, -1, -1);
        check_int("no_de_without_vsync", f_total, 0);
        run_frame(NLINES, 0, -1, 1'b1, -1, -1);
        check_frame("after_reset", VS_LINES + V_BP);

        run_random(250);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
